// File: rtl/alu_result_fifo_pkg.sv
// Shared ALU definitions: result/opcode widths, operand limits and the
// packed entry type that pairs an ALU result with its opcode.
package alu_result_fifo_pkg;

  localparam int RES_W      = 5;
  localparam int OP_W       = 2;
  localparam int MAXPOS     = 7;
  localparam int MAXNEG     = -8;
  localparam int FIFO_DEPTH = 8;
  localparam int DROP_CNT_W = 8;

  typedef logic signed [RES_W-1:0] result_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    result_t         res;
  } alu_entry_t;

  // Builds a stored entry from an opcode/result pair; the result is kept as-is.
  function automatic alu_entry_t pack_entry(input logic [OP_W-1:0] op, input result_t res);
    alu_entry_t e;
    e.op  = op;
    e.res = res;
    return e;
  endfunction

endpackage

// File: rtl/alu_fifo_if.sv
// Bundle of the result FIFO signals, used by the bench to drive and observe
// one FIFO instance. TEST drives the producer/consumer side.
interface alu_fifo_if #(
  parameter int RES_W  = alu_result_fifo_pkg::RES_W,
  parameter int OP_W   = alu_result_fifo_pkg::OP_W,
  parameter int DEPTH  = alu_result_fifo_pkg::FIFO_DEPTH,
  parameter int DROP_W = alu_result_fifo_pkg::DROP_CNT_W
) (
  input logic clk
);

  logic                     reset;
  logic                     in_valid;
  logic signed [RES_W-1:0]  C;
  logic [OP_W-1:0]          opcode;
  logic                     out_ready;
  logic                     out_valid;
  logic signed [RES_W-1:0]  out_data;
  logic [OP_W-1:0]          out_opcode;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic [DROP_W-1:0]        drop_cnt;

  modport TEST (
    input  clk, out_valid, out_data, out_opcode, count, full, empty, drop_cnt,
    output reset, in_valid, C, opcode, out_ready
  );

endinterface

// File: rtl/alu_result_fifo_ptr_ctrl.sv
// Pointer control for the result FIFO: owns the read/write pointers, derives
// occupancy/full/empty and qualifies push and pop from the handshake inputs.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fifo_ptr_ctrl #(
  parameter int DEPTH = alu_result_fifo_pkg::FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       out_ready,
  output logic                       push,
  output logic                       pop,
  output logic [$clog2(DEPTH)-1:0]   wr_addr,
  output logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       out_valid
);

  import alu_result_fifo_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign wr_addr   = wr_ptr[AW-1:0];
  assign rd_addr   = rd_ptr[AW-1:0];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count     = wr_ptr - rd_ptr;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push      = in_valid && (!full || pop);

  // Advance each pointer on its qualified transfer; the wrap bit toggles naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/alu_result_fifo.sv
// Result FIFO behind the 4-bit signed ALU: buffers {opcode, result} pairs,
// presents the head show-ahead under valid/ready and counts results that
// arrive while the buffer is full and cannot be accepted.
module alu_result_fifo #(
  parameter int RES_W  = alu_result_fifo_pkg::RES_W,
  parameter int OP_W   = alu_result_fifo_pkg::OP_W,
  parameter int DEPTH  = alu_result_fifo_pkg::FIFO_DEPTH,
  parameter int DROP_W = alu_result_fifo_pkg::DROP_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [RES_W-1:0]         C,
  input  logic [OP_W-1:0]          opcode,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [RES_W-1:0]         out_data,
  output logic [OP_W-1:0]          out_opcode,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [DROP_W-1:0]        drop_cnt
);

  import alu_result_fifo_pkg::*;

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = RES_W + OP_W;

  logic               push;
  logic               pop;
  logic               drop;
  logic [AW-1:0]      wr_addr;
  logic [AW-1:0]      rd_addr;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] mem [DEPTH];

  fifo_ptr_ctrl #(
    .DEPTH(DEPTH)
  ) u_ptr_ctrl (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .push      (push),
    .pop       (pop),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .out_valid (out_valid)
  );

  // Storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_addr] <= {opcode, C};
  end

  // Show-ahead head; forced to zero while empty so stale data never leaks.
  assign head       = mem[rd_addr];
  assign out_data   = empty ? '0 : head[RES_W-1:0];
  assign out_opcode = empty ? '0 : head[ENTRY_W-1:RES_W];

  assign drop = in_valid && full && !pop;

  // Count discarded results, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
